// File: rtl/key_display_mux.sv
// Two-digit key history display: captures hex key pulses and time-multiplexes
// the newest/previous codes onto an active-low seven-segment bus with blanking.
module key_display_mux #(
    parameter int unsigned REFRESH_DIV = 24000,
    parameter int unsigned DEAD_CYCLES = 16,
    parameter int unsigned CNT_W       = 16
) (
    input  logic       int_osc,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic [6:0] seg,
    output logic [1:0] enable_seg,
    output logic [3:0] digit_new,
    output logic [3:0] digit_old
);

    typedef enum logic [1:0] {SHOW_NEW, BLANK_A, SHOW_OLD, BLANK_B} state_t;

    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] DEAD_LAST  = CNT_W'(DEAD_CYCLES - 1);
    localparam bit               SKIP_BLANK = (DEAD_CYCLES == 0);
    localparam logic [6:0]       SEG_OFF    = 7'h7F;

    function automatic logic [6:0] decode(input logic [3:0] code);
        case (code)
            4'h0: decode = 7'h40;
            4'h1: decode = 7'h79;
            4'h2: decode = 7'h24;
            4'h3: decode = 7'h30;
            4'h4: decode = 7'h19;
            4'h5: decode = 7'h12;
            4'h6: decode = 7'h02;
            4'h7: decode = 7'h78;
            4'h8: decode = 7'h00;
            4'h9: decode = 7'h10;
            4'hA: decode = 7'h08;
            4'hB: decode = 7'h03;
            4'hC: decode = 7'h46;
            4'hD: decode = 7'h21;
            4'hE: decode = 7'h06;
            default: decode = 7'h0E;
        endcase
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       digit_new_q, digit_old_q;
    logic             valid_new_q, valid_old_q;
    logic [6:0]       seg_q, seg_d;
    logic [1:0]       en_q, en_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        seg_d   = SEG_OFF;
        en_d    = 2'b00;
        case (state_q)
            SHOW_NEW: begin
                en_d  = 2'b01;
                seg_d = valid_new_q ? decode(digit_new_q) : SEG_OFF;
                if (cnt_q == SHOW_LAST) begin
                    state_d = SKIP_BLANK ? SHOW_OLD : BLANK_A;
                    cnt_d   = '0;
                end
            end
            BLANK_A: begin
                if (cnt_q == DEAD_LAST) begin
                    state_d = SHOW_OLD;
                    cnt_d   = '0;
                end
            end
            SHOW_OLD: begin
                en_d  = 2'b10;
                seg_d = valid_old_q ? decode(digit_old_q) : SEG_OFF;
                if (cnt_q == SHOW_LAST) begin
                    state_d = SKIP_BLANK ? SHOW_NEW : BLANK_B;
                    cnt_d   = '0;
                end
            end
            default: begin
                if (cnt_q == DEAD_LAST) begin
                    state_d = SHOW_NEW;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    // Display outputs are registered from the pre-edge state and digits,
    // so they trail the FSM by one cycle; key capture never touches the FSM.
    always_ff @(posedge int_osc) begin
        if (reset) begin
            state_q     <= SHOW_NEW;
            cnt_q       <= '0;
            digit_new_q <= '0;
            digit_old_q <= '0;
            valid_new_q <= 1'b0;
            valid_old_q <= 1'b0;
            seg_q       <= SEG_OFF;
            en_q        <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            seg_q   <= seg_d;
            en_q    <= en_d;
            if (key_valid) begin
                digit_old_q <= digit_new_q;
                valid_old_q <= valid_new_q;
                digit_new_q <= key_code;
                valid_new_q <= 1'b1;
            end
        end
    end

    assign seg        = seg_q;
    assign enable_seg = en_q;
    assign digit_new  = digit_new_q;
    assign digit_old  = digit_old_q;

endmodule

// File: tb/tb_key_display_mux.sv
// Scoreboard bench: two instances (blanking 2 and 0) driven by shared stimulus,
// expected outputs derived from slot position and a key-history queue.
module tb_key_display_mux;

    localparam int R = 4;

    typedef struct {
        logic [6:0] seg;
        logic [1:0] en;
        logic [3:0] dn;
        logic [3:0] dold;
    } exp_t;

    localparam logic [6:0] DEC [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = '0;
    logic [6:0] seg0, seg1;
    logic [1:0] en0, en1;
    logic [3:0] dn0, dn1, do0, do1;

    int   checks = 0;
    int   errors = 0;
    int   t0 = 0;
    int   t1 = 0;
    int   keys[$];
    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;

    key_display_mux #(.REFRESH_DIV(R), .DEAD_CYCLES(2), .CNT_W(8)) dut0 (
        .int_osc(clk), .reset(rst), .key_valid(key_valid), .key_code(key_code),
        .seg(seg0), .enable_seg(en0), .digit_new(dn0), .digit_old(do0));

    key_display_mux #(.REFRESH_DIV(R), .DEAD_CYCLES(0), .CNT_W(8)) dut1 (
        .int_osc(clk), .reset(rst), .key_valid(key_valid), .key_code(key_code),
        .seg(seg1), .enable_seg(en1), .digit_new(dn1), .digit_old(do1));

    function automatic exp_t disp(input int t, input int dead, input bit vn, input int pn,
                                  input bit vo, input int po);
        exp_t e;
        int p;
        p = t % (2 * (R + dead));
        e.seg = 7'h7F;
        e.en = 2'b00;
        e.dn = '0;
        e.dold = '0;
        if (p < R) begin
            e.en = 2'b01;
            if (vn) e.seg = DEC[pn];
        end else if (p >= R + dead && p < 2 * R + dead) begin
            e.en = 2'b10;
            if (vo) e.seg = DEC[po];
        end
        return e;
    endfunction

    task automatic cycle(input bit r, input bit kv, input logic [3:0] kc);
        exp_t e0, e1;
        bit vn, vo;
        int pn, po;
        @(negedge clk);
        rst = r;
        key_valid = kv;
        key_code = kc;
        vn = keys.size() >= 1;
        vo = keys.size() >= 2;
        pn = vn ? keys[keys.size() - 1] : 0;
        po = vo ? keys[keys.size() - 2] : 0;
        if (r) begin
            keys.delete();
            t0 = 0;
            t1 = 0;
            e0 = '{seg: 7'h7F, en: 2'b00, dn: 4'h0, dold: 4'h0};
            e1 = e0;
        end else begin
            e0 = disp(t0, 2, vn, pn, vo, po);
            e1 = disp(t1, 0, vn, pn, vo, po);
            t0++;
            t1++;
            if (kv) keys.push_back(int'(kc));
            if (keys.size() > 2) void'(keys.pop_front());
            e0.dn   = (keys.size() >= 1) ? 4'(keys[keys.size() - 1]) : 4'h0;
            e0.dold = (keys.size() >= 2) ? 4'(keys[keys.size() - 2]) : 4'h0;
            e1.dn   = e0.dn;
            e1.dold = e0.dold;
        end
        q0.push_back(e0);
        q1.push_back(e1);
    endtask

    task automatic check(input string name, input int id, input logic [7:0] act,
                         input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d t=%0t got %0h expected %0h", name, id, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            check("seg", 0, {1'b0, seg0}, {1'b0, e.seg});
            check("enable_seg", 0, {6'b0, en0}, {6'b0, e.en});
            check("digit_new", 0, {4'b0, dn0}, {4'b0, e.dn});
            check("digit_old", 0, {4'b0, do0}, {4'b0, e.dold});
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            check("seg", 1, {1'b0, seg1}, {1'b0, e.seg});
            check("enable_seg", 1, {6'b0, en1}, {6'b0, e.en});
            check("digit_new", 1, {4'b0, dn1}, {4'b0, e.dn});
            check("digit_old", 1, {4'b0, do1}, {4'b0, e.dold});
        end
    end

    initial begin
        repeat (3) cycle(1'b1, 1'b0, 4'h0);
        repeat (30) cycle(1'b0, 1'b0, 4'h0);
        cycle(1'b0, 1'b1, 4'h5);
        repeat (20) cycle(1'b0, 1'b0, 4'h0);
        cycle(1'b0, 1'b1, 4'hA);
        repeat (20) cycle(1'b0, 1'b0, 4'h0);
        cycle(1'b0, 1'b1, 4'hC);
        repeat (30) cycle(1'b0, 1'b0, 4'h0);

        // Key on the last SHOW_NEW cycle of the blanking instance.
        while (t0 % 12 != R - 1) cycle(1'b0, 1'b0, 4'h0);
        cycle(1'b0, 1'b1, 4'h7);
        repeat (26) cycle(1'b0, 1'b0, 4'h0);

        // Reset in the middle of SHOW_OLD with history {A,C}.
        cycle(1'b0, 1'b1, 4'hA);
        cycle(1'b0, 1'b1, 4'hC);
        while (t0 % 12 != 7) cycle(1'b0, 1'b0, 4'h0);
        cycle(1'b1, 1'b0, 4'h0);
        repeat (30) cycle(1'b0, 1'b0, 4'h0);

        for (int c = 0; c < 16; c++) begin
            cycle(1'b0, 1'b1, 4'(c));
            repeat (12) cycle(1'b0, 1'b0, 4'h0);
        end

        for (int i = 0; i < 1500; i++)
            cycle($urandom_range(99) == 0, $urandom_range(3) == 0, 4'($urandom_range(15)));

        @(negedge clk);
        rst = 1'b0;
        key_valid = 1'b0;
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
